// File: rtl/mod_exp_engine_if.sv
// Request/response bundle for mod_exp_engine: operands and start in,
// busy/done/result/error out.
interface mod_exp_engine_if #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128
);
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     modulus;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic                 error;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, result, error
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, result, error
  );
endinterface

// File: rtl/mod_exp_engine.sv
// Constant-time left-to-right modular exponentiation built on a bit-serial
// interleaved shift-add modular multiplier (WIDTH cycles per multiply).
//
// state  | meaning
// IDLE   | waiting for start; result/error hold the last outcome
// SQUARE | acc = acc*acc mod n, one multiplier bit per cycle
// MULT   | t = acc*base mod n; acc takes t only when the exponent bit is 1
// DONE   | one-cycle completion pulse; a new start is accepted here
module mod_exp_engine #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128
) (
  input  logic            clk,
  input  logic            reset,
  mod_exp_engine_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(WIDTH - 1);
  localparam logic [EW-1:0] BIT_LAST = EW'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SQUARE, S_MULT, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     base_q, mod_q, acc_q, res_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH+1:0]     p_q;
  logic [CW-1:0]        cyc_q;
  logic [EW-1:0]        bit_q;
  logic                 err_q;

  logic             accept, op_fault, mul_last, mul_bit;
  logic [WIDTH+1:0] p_dbl, p_sub1, p_red, mod_ext;

  // p < n always holds between steps, so 2p + a < 3n fits in WIDTH+2 bits
  // and two conditional subtractions bring it back below n.
  always_comb begin
    accept   = bus.start && (state == S_IDLE || state == S_DONE);
    op_fault = (bus.modulus == '0) || (bus.base >= bus.modulus);
    mul_last = (cyc_q == '0);
    mul_bit  = (state == S_SQUARE) ? acc_q[cyc_q] : base_q[cyc_q];
    mod_ext  = {2'b00, mod_q};
    p_dbl    = (p_q << 1) + (mul_bit ? {2'b00, acc_q} : '0);
    p_sub1   = (p_dbl >= mod_ext) ? p_dbl - mod_ext : p_dbl;
    p_red    = (p_sub1 >= mod_ext) ? p_sub1 - mod_ext : p_sub1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_nxt = op_fault ? S_DONE : S_SQUARE;
        else if (state == S_DONE)
          state_nxt = S_IDLE;
      end
      S_SQUARE: if (mul_last) state_nxt = S_MULT;
      S_MULT:   if (mul_last) state_nxt = (bit_q == '0) ? S_DONE : S_SQUARE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      base_q <= '0;
      mod_q  <= '0;
      exp_q  <= '0;
      acc_q  <= '0;
      p_q    <= '0;
      cyc_q  <= '0;
      bit_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            base_q <= bus.base;
            exp_q  <= bus.exponent;
            mod_q  <= bus.modulus;
            p_q    <= '0;
            cyc_q  <= CYC_LAST;
            bit_q  <= BIT_LAST;
            if (op_fault) begin
              res_q <= '0;
              err_q <= 1'b1;
            end else begin
              acc_q <= (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
            end
          end
        end
        S_SQUARE: begin
          if (mul_last) begin
            acc_q <= p_red[WIDTH-1:0];
            p_q   <= '0;
            cyc_q <= CYC_LAST;
          end else begin
            p_q   <= p_red;
            cyc_q <= cyc_q - 1'b1;
          end
        end
        S_MULT: begin
          if (mul_last) begin
            if (exp_q[bit_q])
              acc_q <= p_red[WIDTH-1:0];
            p_q   <= '0;
            cyc_q <= CYC_LAST;
            if (bit_q == '0) begin
              res_q <= exp_q[bit_q] ? p_red[WIDTH-1:0] : acc_q;
              err_q <= 1'b0;
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end else begin
            p_q   <= p_red;
            cyc_q <= cyc_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == S_SQUARE) || (state == S_MULT);
  assign bus.done   = (state == S_DONE);
  assign bus.result = res_q;
  assign bus.error  = err_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine: a 16-bit instance for function,
// latency and handshake, and a 128-bit instance for an RSA round trip.
module tb_mod_exp_engine;
  localparam int LAT16  = 2 * 16 * 16 + 1;
  localparam int LAT128 = 2 * 128 * 128 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  mod_exp_engine_if #(.WIDTH(16), .EXP_WIDTH(16))   if16 ();
  mod_exp_engine_if #(.WIDTH(128), .EXP_WIDTH(128)) if128 ();

  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .bus(if16)
  );
  mod_exp_engine #(.WIDTH(128), .EXP_WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .bus(if128)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are scrambled right after the accepting edge to prove capture.
  task automatic launch16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
    @(negedge clk);
    if16.start = 1'b1; if16.base = b; if16.exponent = e; if16.modulus = m;
    @(posedge clk); #1;
    if16.start = 1'b0; if16.base = 16'hbeef; if16.exponent = 16'h1234; if16.modulus = 16'h0003;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if16.done && lat < LAT16 + 20);
  endtask

  task automatic run16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       output logic [15:0] r, output logic er, output int lat);
    launch16(b, e, m);
    wait16(lat);
    r  = if16.result;
    er = if16.error;
  endtask

  task automatic run128(input logic [127:0] b, input logic [127:0] e, input logic [127:0] m,
                        output logic [127:0] r, output logic er, output int lat);
    @(negedge clk);
    if128.start = 1'b1; if128.base = b; if128.exponent = e; if128.modulus = m;
    @(posedge clk); #1;
    if128.start = 1'b0; if128.base = '1; if128.exponent = '0; if128.modulus = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if128.done && lat < LAT128 + 20);
    r  = if128.result;
    er = if128.error;
  endtask

  function automatic logic [255:0] gcd(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [255:0] modinv(input logic [255:0] a, input logic [255:0] m);
    logic [255:0] t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a;
    while (nr != 0) begin
      q   = r / nr;
      tmp = (t + m - (q * nt) % m) % m;
      t   = nt;
      nt  = tmp;
      tmp = r - q * nr;
      r   = nr;
      nr  = tmp;
    end
    return t;
  endfunction

  function automatic logic [255:0] ref_modexp(input logic [255:0] b, input logic [255:0] e,
                                              input logic [255:0] n);
    logic [255:0] r;
    r = 1 % n;
    for (int i = 127; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  logic [15:0]  r16;
  logic         er;
  int           lat, done_cnt;
  logic [255:0] p_big, q_big, n_big, phi, e_big, d_big, msg, ct_ref;
  logic [127:0] r128;

  initial begin
    reset = 1'b1;
    if16.start = 1'b0; if16.base = '0; if16.exponent = '0; if16.modulus = '0;
    if128.start = 1'b0; if128.base = '0; if128.exponent = '0; if128.modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(if16.busy), 0);
    chk("rst_done", 256'(if16.done), 0);
    chk("rst_result", 256'(if16.result), 0);
    chk("rst_error", 256'(if16.error), 0);
    @(negedge clk);
    reset = 1'b0;

    // Reference vector, one-cycle done pulse and hold in IDLE
    run16(16'd4, 16'd13, 16'd497, r16, er, lat);
    chk("ref_latency", 256'(lat), 256'(LAT16));
    chk("ref_result", 256'(r16), 445);
    chk("ref_error", 256'(er), 0);
    chk("ref_busy_in_done", 256'(if16.busy), 0);
    @(negedge clk);
    chk("done_single_cycle", 256'(if16.done), 0);
    repeat (5) @(negedge clk);
    chk("result_hold_idle", 256'(if16.result), 445);

    run16(16'd65, 16'd17, 16'd3233, r16, er, lat);
    chk("rsa_encrypt", 256'(r16), 2790);
    run16(16'd2790, 16'd2753, 16'd3233, r16, er, lat);
    chk("rsa_decrypt", 256'(r16), 65);
    chk("rsa_decrypt_err", 256'(er), 0);

    run16(16'd123, 16'd0, 16'd497, r16, er, lat);
    chk("exp0_mod497", 256'(r16), 1);
    run16(16'd0, 16'd9, 16'd1, r16, er, lat);
    chk("mod1_result", 256'(r16), 0);
    chk("mod1_error", 256'(er), 0);
    run16(16'd5, 16'd0, 16'd7, r16, er, lat);
    chk("b5_exp0_mod7", 256'(r16), 1);

    run16(16'd3, 16'd5, 16'd0, r16, er, lat);
    chk("mod0_latency", 256'(lat), 1);
    chk("mod0_error", 256'(er), 1);
    chk("mod0_result", 256'(r16), 0);
    run16(16'd500, 16'd3, 16'd497, r16, er, lat);
    chk("base_ge_mod_latency", 256'(lat), 1);
    chk("base_ge_mod_error", 256'(er), 1);
    chk("base_ge_mod_result", 256'(r16), 0);

    // A clean run right after a fault must clear error
    run16(16'd4, 16'd13, 16'd497, r16, er, lat);
    chk("after_fault_error", 256'(er), 0);
    // Start issued inside the DONE cycle is taken immediately
    if16.start = 1'b1; if16.base = 16'd5; if16.exponent = 16'd0; if16.modulus = 16'd7;
    @(posedge clk); #1;
    if16.start = 1'b0;
    chk("start_in_done_busy", 256'(if16.busy), 1);
    chk("start_in_done_old_result", 256'(if16.result), 445);
    wait16(lat);
    chk("start_in_done_latency", 256'(lat), 256'(LAT16));
    chk("start_in_done_result", 256'(if16.result), 1);

    // Start while busy is ignored
    launch16(16'd65, 16'd17, 16'd3233);
    repeat (50) @(negedge clk);
    if16.start = 1'b1; if16.base = 16'd9; if16.exponent = 16'd1; if16.modulus = 16'd0;
    @(posedge clk); #1;
    if16.start = 1'b0;
    wait16(lat);
    chk("busy_start_ignored_done", 256'(if16.done), 1);
    chk("busy_start_ignored_result", 256'(if16.result), 2790);
    chk("busy_start_ignored_error", 256'(if16.error), 0);
    @(negedge clk);
    chk("busy_start_no_rerun", 256'(if16.busy), 0);

    // Reset mid-operation
    launch16(16'd4, 16'd13, 16'd497);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_busy", 256'(if16.busy), 0);
    chk("midreset_result", 256'(if16.result), 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (if16.done) done_cnt++;
    end
    chk("midreset_no_done", 256'(done_cnt), 0);
    run16(16'd4, 16'd13, 16'd497, r16, er, lat);
    chk("after_reset_result", 256'(r16), 445);
    chk("after_reset_latency", 256'(lat), 256'(LAT16));

    // Reset wins over start on the same edge
    @(negedge clk);
    reset = 1'b1;
    if16.start = 1'b1; if16.base = 16'd4; if16.exponent = 16'd13; if16.modulus = 16'd497;
    @(posedge clk); #1;
    chk("reset_vs_start_busy", 256'(if16.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    if16.start = 1'b0;
    @(posedge clk); #1;
    chk("reset_vs_start_discarded", 256'(if16.busy), 0);

    // 128-bit RSA round trip
    p_big = 256'd113680897410347;
    q_big = 256'd7999808077935876437321;
    n_big = p_big * q_big;
    phi   = (p_big - 1) * (q_big - 1);
    e_big = 256'd65537;
    if (gcd(e_big, phi) != 1) e_big = 256'd17;
    if (gcd(e_big, phi) != 1) e_big = 256'd3;
    d_big  = modinv(e_big, phi);
    msg    = 256'h57000000;
    ct_ref = ref_modexp(msg, e_big, n_big);
    run128(msg[127:0], e_big[127:0], n_big[127:0], r128, er, lat);
    chk("w128_encrypt_latency", 256'(lat), 256'(LAT128));
    chk("w128_ciphertext", 256'(r128), ct_ref);
    chk("w128_encrypt_error", 256'(er), 0);
    run128(r128, d_big[127:0], n_big[127:0], r128, er, lat);
    chk("w128_roundtrip", 256'(r128), msg);
    chk("w128_decrypt_error", 256'(er), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
